// File: rtl/gpio_seq_pkg.sv
// gpio_seq_pkg: shared definitions for the GPIO pattern sequencer.
//   - Register word offsets, selected by PADDR[4:2].
//   - The sequencer state enum.
//   - Bit positions inside CTRL, STATUS and IRQEN.
// Optional build macro used by the sequencer: GPIO_SEQ_RX_EN (RX capture path).
package gpio_seq_pkg;

  // Register word offsets (byte address >> 2)
  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_DIV    = 3'd1;
  localparam logic [2:0] REG_DIR    = 3'd2;
  localparam logic [2:0] REG_TXDATA = 3'd3;
  localparam logic [2:0] REG_RXDATA = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;
  localparam logic [2:0] REG_IRQEN  = 3'd6;
  localparam logic [2:0] REG_THRESH = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } seq_state_t;

  // CTRL bits
  localparam int CTRL_RUN   = 0;
  localparam int CTRL_TXCLR = 2;
  localparam int CTRL_RXCLR = 3;

  // STATUS bits
  localparam int STAT_UNDERFLOW = 18;
  localparam int STAT_OVERFLOW  = 19;

  // IRQEN / pending bits
  localparam int IRQ_TXLOW  = 0;
  localparam int IRQ_RXHIGH = 1;
  localparam int IRQ_ERR    = 2;

endpackage

// File: rtl/gpio_seq_fifo.sv
// gpio_seq_fifo: synchronous FIFO, W bits wide, DEPTH entries (power of two).
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   push, wdata     write request and data; accepted when not full, or when
//                   a pop happens in the same cycle
//   pop, rdata      read request; rdata always shows the head entry
//   clr             empties the FIFO in one cycle (wins over push/pop)
//   full, empty     status flags
//   level           number of stored entries (0..DEPTH)
module gpio_seq_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clr,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (PW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop frees a slot in the same cycle, so a push at full still lands.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

  // Storage needs no reset: level alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/gpio_seq_apb.sv
// gpio_seq_apb: APB pattern sequencer for a GPIO bank. Software queues words
// into a TX FIFO; on every tick the sequencer pops one onto gpio_out and
// captures gpio_in into an RX FIFO.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA  APB request (PADDR[4:2] selects register)
//   PRDATA/PREADY/PSLVERR          APB response (zero wait states)
//   gpio_in                        synchronised pin inputs
//   gpio_out, gpio_dir             pin values and output enables
//   irq                            registered level interrupt
// Build macro: GPIO_SEQ_RX_EN builds the RX FIFO and capture path; without it
// RXDATA always errors, rx level/overflow read 0 and rxclr is ignored.
module gpio_seq_apb #(
  parameter int GW    = 32,
  parameter int DEPTH = 8,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] PADDR,
  input  logic          PSEL,
  input  logic          PENABLE,
  input  logic          PWRITE,
  input  logic [31:0]   PWDATA,
  output logic [31:0]   PRDATA,
  output logic          PREADY,
  output logic          PSLVERR,
  input  logic [GW-1:0] gpio_in,
  output logic [GW-1:0] gpio_out,
  output logic [GW-1:0] gpio_dir,
  output logic          irq
);
  import gpio_seq_pkg::*;

  localparam int LW = $clog2(DEPTH) + 1;

  seq_state_t    state;
  logic          run;
  logic [15:0]   div;
  logic [15:0]   cnt;
  logic [GW-1:0] dir;
  logic [2:0]    irqen;
  logic [7:0]    txthresh;
  logic [7:0]    rxthresh;
  logic          underflow;
  logic          overflow;

  logic          access, addr_ok, wr_en, rd_en;
  logic [2:0]    reg_sel;
  logic          ctrl_wr, status_wr, tx_push_req, rx_pop_req;
  logic          run_nxt, tick, tx_pop, capture, udf_set, ovf_set;
  logic          tx_full, tx_empty, rx_empty;
  logic [GW-1:0] tx_rdata, rx_rdata;
  logic [LW-1:0] tx_level, rx_level;
  logic [7:0]    tx_lvl8, rx_lvl8;
  logic [2:0]    pending;
  logic [31:0]   status_word;

  assign access      = PSEL & PENABLE;
  assign addr_ok     = (PADDR[AW-1:5] == '0);
  assign reg_sel     = PADDR[4:2];
  assign wr_en       = access & PWRITE & addr_ok;
  assign rd_en       = access & ~PWRITE & addr_ok;
  assign ctrl_wr     = wr_en & (reg_sel == REG_CTRL);
  assign status_wr   = wr_en & (reg_sel == REG_STATUS);
  assign tx_push_req = wr_en & (reg_sel == REG_TXDATA);
  assign rx_pop_req  = rd_en & (reg_sel == REG_RXDATA);
  assign PREADY      = 1'b1;
  assign gpio_dir    = dir;

  // The FSM follows the run value being committed, so run=1 enters RUN and
  // run=0 enters IDLE on the same edge that writes CTRL.
  assign run_nxt = ctrl_wr ? PWDATA[CTRL_RUN] : run;
  assign tick    = (state != ST_IDLE) && (cnt >= div);
  assign tx_pop  = tick & ~tx_empty;
  assign capture = tx_pop;
  assign udf_set = tick & tx_empty;

  gpio_seq_fifo #(.W(GW), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push_req),
    .pop   (tx_pop),
    .clr   (ctrl_wr & PWDATA[CTRL_TXCLR]),
    .wdata (PWDATA[GW-1:0]),
    .rdata (tx_rdata),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level)
  );

`ifdef GPIO_SEQ_RX_EN
  logic rx_full;
  logic unused_bits;

  gpio_seq_fifo #(.W(GW), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (capture),
    .pop   (rx_pop_req),
    .clr   (ctrl_wr & PWDATA[CTRL_RXCLR]),
    .wdata (gpio_in),
    .rdata (rx_rdata),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level)
  );

  // A concurrent software pop makes room, so only then is the sample kept.
  assign ovf_set     = capture & rx_full & ~rx_pop_req;
  assign unused_bits = ^PADDR[1:0];
`else
  logic unused_bits;

  assign rx_rdata    = '0;
  assign rx_empty    = 1'b1;
  assign rx_level    = '0;
  assign ovf_set     = 1'b0;
  assign unused_bits = ^{PADDR[1:0], gpio_in};
`endif

  assign tx_lvl8 = 8'(tx_level);
  assign rx_lvl8 = 8'(rx_level);

  assign pending[IRQ_ERR]    = underflow | overflow;
  assign pending[IRQ_RXHIGH] = (rx_lvl8 >= rxthresh) && (rx_lvl8 != 8'd0);
  assign pending[IRQ_TXLOW]  = (tx_lvl8 <= txthresh);

  assign status_word = {12'd0, overflow, underflow, 2'(state), rx_lvl8, tx_lvl8};

  // APB read data and error response, valid only during the access phase.
  always_comb begin
    PRDATA  = '0;
    PSLVERR = 1'b0;
    if (access) begin
      if (!addr_ok) begin
        PSLVERR = 1'b1;
      end else begin
        case (reg_sel)
          REG_CTRL:   PRDATA[CTRL_RUN] = run;
          REG_DIV:    PRDATA[15:0] = div;
          REG_DIR:    PRDATA[GW-1:0] = dir;
          REG_TXDATA: PSLVERR = PWRITE & tx_full & ~tx_pop;
          REG_RXDATA: begin
            if (!PWRITE) begin
              if (rx_empty) PSLVERR = 1'b1;
              else          PRDATA[GW-1:0] = rx_rdata;
            end
          end
          REG_STATUS: PRDATA = status_word;
          REG_IRQEN:  PRDATA[2:0] = irqen;
          REG_THRESH: PRDATA[15:0] = {rxthresh, txthresh};
          default:    PRDATA = '0;
        endcase
      end
    end
  end

  // Software-visible configuration, sticky error flags and the irq register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run       <= 1'b0;
      div       <= '0;
      dir       <= '0;
      irqen     <= '0;
      txthresh  <= '0;
      rxthresh  <= '0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (wr_en) begin
        case (reg_sel)
          REG_CTRL:   run <= PWDATA[CTRL_RUN];
          REG_DIV:    div <= PWDATA[15:0];
          REG_DIR:    dir <= PWDATA[GW-1:0];
          REG_IRQEN:  irqen <= PWDATA[2:0];
          REG_THRESH: begin
            txthresh <= PWDATA[7:0];
            rxthresh <= PWDATA[15:8];
          end
          default: ;
        endcase
      end
      // A new event in the same cycle as the W1C keeps the flag set.
      if (udf_set)                                  underflow <= 1'b1;
      else if (status_wr && PWDATA[STAT_UNDERFLOW]) underflow <= 1'b0;
      if (ovf_set)                                  overflow <= 1'b1;
      else if (status_wr && PWDATA[STAT_OVERFLOW])  overflow <= 1'b0;
      irq <= |(pending & irqen);
    end
  end

  // Sequencer FSM with tick counter and the registered pin outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      gpio_out <= '0;
    end else begin
      if (tx_pop) gpio_out <= tx_rdata;
      if (!run_nxt) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_RUN;
            cnt   <= '0;
          end
          ST_RUN, ST_STALL: begin
            cnt <= tick ? 16'd0 : cnt + 16'd1;
            if (tick) state <= tx_empty ? ST_STALL : ST_RUN;
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/gpio_seq_apb.md
# gpio_seq_apb

APB-attached, parametrised pattern sequencer for a GPIO bank: software queues output words into a TX FIFO and the block replays them onto the pins at a programmable tick rate. On every tick it also captures the pin inputs into an RX FIFO. It is the next-generation replacement for the fixed-width PIO bus wrapper, in the same peripheral slot. It adds variable bank width, FIFO depth, rate control, underflow/overflow tracking and a threshold interrupt.

## Interface
- GW, 32: GPIO bank width, 1..32.
- DEPTH, 8: entries per FIFO, power of two, 2..128.
- AW, 12: APB address width.

Ports:
- clk  in  1  single clock for the APB bus and the sequencer.
- reset  in  1  asynchronous, active-high reset.
- PADDR  in  AW  APB address; bits [4:2] select the register.
- PSEL, PENABLE, PWRITE  in  1 each  standard APB controls.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  tied to 1 (zero wait states).
- PSLVERR  out  1  error response.
- gpio_in  in  GW  pin inputs, already synchronised upstream.
- gpio_out  out  GW  pin output values.
- gpio_dir  out  GW  pin output enables (1 = drive).
- irq  out  1  level interrupt.

## Operation
Registers (word offsets):
- 0x00 CTRL: [0] run; [2] txclr (self-clearing); [3] rxclr (self-clearing).
- 0x04 DIV: [15:0] tick period minus 1.
- 0x08 DIR: [GW-1:0] drives gpio_dir.
- 0x0C TXDATA: write pushes [GW-1:0]. Read returns 0.
- 0x10 RXDATA: read pops one entry.
- 0x14 STATUS: [7:0] tx level; [15:8] rx level; [17:16] state; [18] underflow (W1C); [19] overflow (W1C).
- 0x18 IRQEN: [0] tx low; [1] rx high; [2] error.
- 0x1C THRESH: [7:0] txthresh; [15:8] rxthresh.
- Any other offset: reads 0, PSLVERR=1, writes ignored.

Error responses:
- Push to a full TX FIFO: PSLVERR=1, data dropped. Exception: a pop in the same cycle makes the push succeed.
- Pop from an empty RX FIFO: PRDATA=0, PSLVERR=1.

Tick counter:
- Counts 0..DIV, asserting tick at DIV, then returns to 0.
- Held at 0 whenever the state is IDLE.

State machine (IDLE=0, RUN=1, STALL=2):
- IDLE → RUN when run=1.
- RUN, on each tick:
  - TX not empty: pop into gpio_out and push gpio_in into the RX FIFO.
  - TX empty: go to STALL, set underflow, gpio_out holds.
- STALL → RUN on the first tick where TX is not empty; that tick pops normally.
- Any state → IDLE the cycle after run=0. gpio_out holds its last value.

RX capture:
- RX FIFO full on a capture: sample dropped, overflow set.

Interrupt:
- pending = {underflow|overflow, rxlvl>=rxthresh && rxlvl!=0, txlvl<=txthresh}.
- irq = |(pending & IRQEN), registered.

Clear controls:
- txclr/rxclr empty the FIFO in one cycle. They do not change the state.

## Timing
- Reset values:
  - gpio_out=0, gpio_dir=0, irq=0.
  - All registers and FIFOs cleared; state IDLE.
  - PRDATA=0, PSLVERR=0, PREADY=1.
- Every APB access completes in its access phase.
- PRDATA and PSLVERR are combinational during PSEL&PENABLE and 0 otherwise.
- Writes take effect at the clock edge ending the access phase.
- First tick: DIV+1 cycles after the edge that commits run=1.
- gpio_out changes at the tick edge, so it is visible in the cycle after tick. The gpio_in capture uses the value present in the tick cycle.
- irq lags pending by 1 cycle. A W1C clears the sticky bits on the commit edge; irq drops one cycle later.
- A reset asserted mid-sequence clears everything immediately (asynchronous), including gpio_out.

## Configuration
- GPIO_SEQ_RX_EN defined: RX FIFO and capture path built.
- Not defined:
  - No RX FIFO storage.
  - RXDATA reads 0 with PSLVERR=1.
  - rx level reads 0; overflow and pending[1] are constantly 0.
  - rxclr is ignored.

## Structure
- gpio_seq_pkg holds:
  - Register offset localparams.
  - The state enum (IDLE/RUN/STALL).
  - CTRL/STATUS/IRQEN bit-position localparams.
- Sub-module gpio_seq_fifo: synchronous FIFO parametrised by width and depth.
  - Provides push, pop, clr, full, empty and level, with simultaneous push/pop at full allowed.
  - Instantiated for TX and, under the macro, for RX.

## Test plan
- Reset release: gpio_out=0, gpio_dir=0, irq=0. STATUS reads 0x0, tx level 0.
- DIR=0xFF, DIV=3, push 0xA5,0x5A, run=1:
  - gpio_out=0xA5 from 5 cycles after the commit, 0x5A 4 cycles later.
  - Then STALL with underflow=1 and gpio_out held at 0x5A.
- DEPTH=8: push 9 words with run=0. The 9th returns PSLVERR=1 and tx level reads 8.
- RX path:
  - gpio_in=0x3C during 3 ticks with rxthresh=3, IRQEN=0x2: irq rises 1 cycle after the 3rd capture.
  - Three RXDATA reads return 0x3C; the 4th returns 0 with PSLVERR=1.
- Reset mid-sequence: clear run mid-sequence, then assert reset.
  - run=0: state reads IDLE next cycle.
  - reset: gpio_out goes to 0 immediately and FIFO levels go to 0.
- Access to offset 0x20: PRDATA=0, PSLVERR=1, no register changes. Write 0xC0000 to STATUS: underflow and overflow clear.
